// File: rtl/comma_frame_tx.sv
// Serial comma framer: sends comma 101, then the payload LSB-first with zero-stuffing so 101 never
// appears outside a comma. Optional even-parity bit appended when COMMA_PARITY_EN is defined.
module comma_frame_tx #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_SIZE  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 load,
    output logic                 busy,
    output logic                 serial_out,
    output logic                 done,
    output logic                 stuff
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_COMMA  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef COMMA_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_GAP    = 3'd4;

    localparam logic [CNT_SIZE-1:0] LAST_CNT = CNT_SIZE'(WORD_SIZE - 1);

    logic [2:0]           state_q, state_d;
    logic [WORD_SIZE-1:0] shreg_q, shreg_d;
    logic [CNT_SIZE-1:0]  cnt_q, cnt_d;
    logic [1:0]           sub_q, sub_d;
    logic [1:0]           hist_q, hist_d;
    logic                 serial_q, serial_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 stuff_q, stuff_d;
`ifdef COMMA_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign busy       = busy_q;
    assign serial_out = serial_q;
    assign done       = done_q;
    assign stuff      = stuff_q;

    // hist_q is {older, newer} of the last two line bits; "10" means a 1 next would form 101.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        hist_d   = hist_q;
        busy_d   = busy_q;
        serial_d = 1'b0;
        done_d   = 1'b0;
        stuff_d  = 1'b0;
`ifdef COMMA_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (load) begin
                    shreg_d = data_in;
                    cnt_d   = '0;
                    sub_d   = 2'd0;
                    busy_d  = 1'b1;
                    state_d = ST_COMMA;
`ifdef COMMA_PARITY_EN
                    parity_d = 1'b0;
`endif
                end
            end
            ST_COMMA: begin
                busy_d   = 1'b1;
                serial_d = (sub_q != 2'd1);
                hist_d   = {hist_q[0], serial_d};
                sub_d    = sub_q + 2'd1;
                if (sub_q == 2'd2) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                busy_d = 1'b1;
                if (hist_q == 2'b10) begin
                    stuff_d = 1'b1;
                    hist_d  = {hist_q[0], 1'b0};
                end else begin
                    serial_d = shreg_q[0];
                    hist_d   = {hist_q[0], shreg_q[0]};
                    shreg_d  = shreg_q >> 1;
                    cnt_d    = cnt_q + CNT_SIZE'(1);
`ifdef COMMA_PARITY_EN
                    parity_d = parity_q ^ shreg_q[0];
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_PARITY;
                    end
`else
                    if (cnt_q == LAST_CNT) begin
                        done_d  = 1'b1;
                        sub_d   = 2'd0;
                        state_d = ST_GAP;
                    end
`endif
                end
            end
`ifdef COMMA_PARITY_EN
            ST_PARITY: begin
                busy_d = 1'b1;
                if (hist_q == 2'b10) begin
                    stuff_d = 1'b1;
                    hist_d  = {hist_q[0], 1'b0};
                end else begin
                    serial_d = parity_q;
                    hist_d   = {hist_q[0], parity_q};
                    done_d   = 1'b1;
                    sub_d    = 2'd0;
                    state_d  = ST_GAP;
                end
            end
`endif
            ST_GAP: begin
                // Two guard zeros keep a trailing 1 or 10 from joining the next comma.
                busy_d = 1'b1;
                hist_d = {hist_q[0], 1'b0};
                sub_d  = sub_q + 2'd1;
                if (sub_q == 2'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            sub_q    <= 2'd0;
            hist_q   <= 2'b00;
            serial_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            stuff_q  <= 1'b0;
`ifdef COMMA_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            hist_q   <= hist_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            stuff_q  <= stuff_d;
`ifdef COMMA_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
